// File: rtl/core_pkg.sv
// Shared rename-stage parameters and types used by the physical-register free list.
// Ring geometry is derived from the architectural/physical register widths.
package core_pkg;

    localparam int PREG       = 6;
    localparam int AREG       = 5;
    localparam int DECODE_NUM = 4;
    localparam int RETIRE_NUM = 4;

    localparam int NUM_PREG = 2 ** PREG;
    localparam int NUM_AREG = 2 ** AREG;
    localparam int FL_DEPTH = NUM_PREG - NUM_AREG;

    localparam int FL_IDX_W = $clog2(FL_DEPTH);
    localparam int FL_PTR_W = FL_IDX_W + 1;
    localparam int FL_CNT_W = $clog2(((DECODE_NUM > RETIRE_NUM) ? DECODE_NUM : RETIRE_NUM) + 1);

    typedef logic [PREG-1:0]     preg_t;
    typedef logic [FL_PTR_W-1:0] ptr_t;
    typedef logic [FL_IDX_W-1:0] idx_t;
    typedef logic [FL_CNT_W-1:0] cnt_t;

    // Ring slot reached from a pointer's index bits plus a compaction offset.
    function automatic idx_t ring_idx(input idx_t base, input cnt_t off);
        return base + idx_t'(off);
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/retire-facing handshake bundle of the physical-register free list.
// master = rename + ROB side, slave = free list.
interface free_list_if;
    import core_pkg::*;

    logic [DECODE_NUM-1:0]  alloc_req;
    logic                   alloc_ready;
    preg_t [DECODE_NUM-1:0] alloc_preg;
    logic [RETIRE_NUM-1:0]  release_v;
    preg_t [RETIRE_NUM-1:0] release_preg;
    ptr_t                   free_count;

    modport master (
        output alloc_req, release_v, release_preg,
        input  alloc_ready, alloc_preg, free_count
    );

    modport slave (
        input  alloc_req, release_v, release_preg,
        output alloc_ready, alloc_preg, free_count
    );

endinterface

// File: rtl/free_list_prefix_popcount.sv
// Exclusive prefix population counts plus total for an N-bit request vector.
// Used to compact sparse alloc/release slots onto consecutive ring entries.
module prefix_popcount #(
    parameter int N = 4,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0]        vec,
    output logic [N-1:0][W-1:0] prefix,
    output logic [W-1:0]        total
);

    logic [W-1:0] acc;

    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = acc;
            acc       = acc + W'(vec[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: circular buffer of unmapped pregs, multi-slot alloc/release.
// Optional FREE_LIST_FLUSH_EN adds a flush port that rewinds head to the committed point.
module free_list
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef FREE_LIST_FLUSH_EN
    input  logic flush,
`endif
    free_list_if.slave fl
);

    ptr_t  head;
    ptr_t  tail;
    ptr_t  free_count;
    preg_t ring [FL_DEPTH];
    logic  alloc_ready;

    logic [DECODE_NUM-1:0][FL_CNT_W-1:0] a_prefix;
    logic [RETIRE_NUM-1:0][FL_CNT_W-1:0] r_prefix;
    cnt_t a_total;
    cnt_t r_total;

`ifdef FREE_LIST_FLUSH_EN
    ptr_t commit_head;
`endif

    prefix_popcount #(.N(DECODE_NUM), .W(FL_CNT_W)) u_alloc_cnt (
        .vec    (fl.alloc_req),
        .prefix (a_prefix),
        .total  (a_total)
    );

    prefix_popcount #(.N(RETIRE_NUM), .W(FL_CNT_W)) u_release_cnt (
        .vec    (fl.release_v),
        .prefix (r_prefix),
        .total  (r_total)
    );

    assign free_count = tail - head;

    always_comb begin
`ifdef FREE_LIST_FLUSH_EN
        alloc_ready = (ptr_t'(a_total) <= free_count) && !flush;
`else
        alloc_ready = (ptr_t'(a_total) <= free_count);
`endif
    end

    // Unrequested slots still read their would-be entry; rename ignores them.
    always_comb begin
        fl.alloc_preg = '0;
        for (int i = 0; i < DECODE_NUM; i++) begin
            fl.alloc_preg[i] = ring[ring_idx(head[FL_IDX_W-1:0], a_prefix[i])];
        end
    end

    assign fl.alloc_ready = alloc_ready;
    assign fl.free_count  = free_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= ptr_t'(FL_DEPTH);
            for (int k = 0; k < FL_DEPTH; k++) begin
                ring[k] <= preg_t'(NUM_AREG + k);
            end
`ifdef FREE_LIST_FLUSH_EN
            commit_head <= '0;
`endif
        end else begin
            if (alloc_ready) begin
                head <= head + ptr_t'(a_total);
            end
            for (int j = 0; j < RETIRE_NUM; j++) begin
                if (fl.release_v[j]) begin
                    ring[ring_idx(tail[FL_IDX_W-1:0], r_prefix[j])] <= fl.release_preg[j];
                end
            end
            tail <= tail + ptr_t'(r_total);
`ifdef FREE_LIST_FLUSH_EN
            // Retirements are in allocation order, so commit_head trails head exactly.
            commit_head <= commit_head + ptr_t'(r_total);
            if (flush) begin
                head <= commit_head + ptr_t'(r_total);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ({1'b0, free_count} + (FL_PTR_W + 1)'(r_total) <= (FL_PTR_W + 1)'(FL_DEPTH))
            else $error("free_list: release overflows ring (free_count=%0d)", free_count);
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, compaction, stall, release reuse, wrap, flush.
// Build with FREE_LIST_FLUSH_EN to also cover the flush recovery path.
module tb_free_list;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef FREE_LIST_FLUSH_EN
    logic flush = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    free_list_if fl ();

    free_list dut (
        .clk   (clk),
        .rst   (rst),
`ifdef FREE_LIST_FLUSH_EN
        .flush (flush),
`endif
        .fl    (fl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] rv, input preg_t [3:0] rp);
        fl.alloc_req    = req;
        fl.release_v    = rv;
        fl.release_preg = rp;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0000, 4'b0000, '0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    preg_t [3:0] rp;

    initial begin
        fl.alloc_req    = '0;
        fl.release_v    = '0;
        fl.release_preg = '0;

        // Reset image and first full-width allocation
        do_reset();
        drive(4'b0000, 4'b0000, '0);
        check("rst_free_count", 32'(fl.free_count), 32);
        check("rst_ready_idle", 32'(fl.alloc_ready), 1);
        drive(4'b1111, 4'b0000, '0);
        check("a1111_ready", 32'(fl.alloc_ready), 1);
        check("a1111_slot0", 32'(fl.alloc_preg[0]), 32);
        check("a1111_slot1", 32'(fl.alloc_preg[1]), 33);
        check("a1111_slot2", 32'(fl.alloc_preg[2]), 34);
        check("a1111_slot3", 32'(fl.alloc_preg[3]), 35);
        tick();
        drive(4'b0000, 4'b0000, '0);
        check("a1111_count", 32'(fl.free_count), 28);

        // Sparse request compaction
        do_reset();
        drive(4'b1010, 4'b0000, '0);
        check("a1010_ready", 32'(fl.alloc_ready), 1);
        check("a1010_slot1", 32'(fl.alloc_preg[1]), 32);
        check("a1010_slot3", 32'(fl.alloc_preg[3]), 33);
        tick();
        drive(4'b1111, 4'b0000, '0);
        check("a1010_count", 32'(fl.free_count), 30);
        check("a1010_next", 32'(fl.alloc_preg[0]), 34);

        // Drain to empty, then stall
        do_reset();
        drive(4'b1111, 4'b0000, '0);
        repeat (8) tick();
        check("empty_count", 32'(fl.free_count), 0);
        check("empty_ready", 32'(fl.alloc_ready), 0);
        check("empty_slot0", 32'(fl.alloc_preg[0]), 32);
        tick();
        check("stall_count", 32'(fl.free_count), 0);
        check("stall_slot0", 32'(fl.alloc_preg[0]), 32);

        // Release at empty; no same-cycle bypass
        rp = {6'd0, 6'd0, 6'd9, 6'd5};
        drive(4'b0001, 4'b0011, rp);
        check("rel_no_bypass", 32'(fl.alloc_ready), 0);
        tick();
        drive(4'b0001, 4'b0000, '0);
        check("rel_ready", 32'(fl.alloc_ready), 1);
        check("rel_count2", 32'(fl.free_count), 2);
        check("rel_first", 32'(fl.alloc_preg[0]), 5);
        tick();
        check("rel_count1", 32'(fl.free_count), 1);
        check("rel_second", 32'(fl.alloc_preg[0]), 9);
        tick();
        drive(4'b0000, 4'b0000, '0);
        check("rel_count0", 32'(fl.free_count), 0);

        // 32 allocations, 32 releases of (100-k) mod 64, then wrap
        do_reset();
        drive(4'b1111, 4'b0000, '0);
        repeat (8) tick();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 4; k++) begin
                rp[k] = preg_t'((100 - (4 * c + k)) % 64);
            end
            drive(4'b0000, 4'b1111, rp);
            tick();
            drive(4'b0000, 4'b0000, '0);
            check("wrap_count_le32", 32'(fl.free_count <= 32), 1);
            check("wrap_count", 32'(fl.free_count), 32'(4 * (c + 1)));
        end
        drive(4'b1111, 4'b0000, '0);
        check("wrap_ready", 32'(fl.alloc_ready), 1);
        check("wrap_slot0", 32'(fl.alloc_preg[0]), 36);
        check("wrap_slot1", 32'(fl.alloc_preg[1]), 35);
        check("wrap_slot3", 32'(fl.alloc_preg[3]), 33);
        tick();

        // Simultaneous allocate and release
        rp = {6'd13, 6'd12, 6'd11, 6'd10};
        drive(4'b1111, 4'b1111, rp);
        check("simul_slot0", 32'(fl.alloc_preg[0]), 32);
        check("simul_slot3", 32'(fl.alloc_preg[3]), 29);
        tick();
        drive(4'b1111, 4'b0000, '0);
        check("simul_count", 32'(fl.free_count), 28);
        check("simul_next", 32'(fl.alloc_preg[0]), 28);
        drive(4'b0000, 4'b0000, '0);

`ifdef FREE_LIST_FLUSH_EN
        // Flush rewinds head to committed point plus same-cycle retirements
        do_reset();
        drive(4'b1111, 4'b0000, '0);
        tick();
        tick();
        drive(4'b0000, 4'b0000, '0);
        check("flush_pre_count", 32'(fl.free_count), 24);
        flush = 1'b1;
        rp = {6'd0, 6'd3, 6'd2, 6'd1};
        drive(4'b1111, 4'b0111, rp);
        check("flush_ready", 32'(fl.alloc_ready), 0);
        tick();
        flush = 1'b0;
        drive(4'b1111, 4'b0000, '0);
        check("flush_count", 32'(fl.free_count), 32);
        check("flush_slot0", 32'(fl.alloc_preg[0]), 35);
        drive(4'b0000, 4'b0000, '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the RV64 out-of-order core. It is a circular buffer of unmapped physical register numbers. Each cycle it hands up to DECODE_NUM registers to rename as new destinations. Each cycle it takes back up to RETIRE_NUM old physical registers released by ROB retirement. It is the receiving end of the ROB's opreg release path and the supplier of rename's `preg` values.

## Interface
- PREG, 6, physical register index width (NUM_PREG = 2^PREG = 64)
- AREG, 5, architectural register index width (NUM_AREG = 2^AREG = 32)
- DECODE_NUM, 4, allocation slots per cycle
- RETIRE_NUM, 4, release slots per cycle
- DEPTH, NUM_PREG-NUM_AREG = 32, ring entries (power of two)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- alloc_req  in  DECODE_NUM  per-slot request; bit i = instruction i has a destination (areg_v)
- alloc_ready  out  1  enough free registers for every set bit of alloc_req; all-or-nothing
- alloc_preg  out  PREG x DECODE_NUM  allocated register per slot; valid only where alloc_req[i] is set and alloc_ready is high
- release_v  in  RETIRE_NUM  per-slot release valid (retire && areg_v)
- release_preg  in  PREG x RETIRE_NUM  old physical register (opreg) being freed
- free_count  out  log2(DEPTH)+1  current number of free entries
- flush  in  1  mispredict/exception recovery; present only with FREE_LIST_FLUSH_EN

## Operation
- Storage: DEPTH x PREG ring. Pointers head and tail are log2(DEPTH)+1 bits wide; the MSB is a wrap bit.
- free_count = tail - head, computed modulo 2^(log2(DEPTH)+1).
- Reset: entry k = NUM_AREG+k; head = 0; tail = DEPTH (wrap bit set). This gives free_count = 32 and alloc_ready = 1.
- Allocation compaction: slot i reads entry head + popcount(alloc_req[i-1:0]). Unrequested slots drive the entry that slot would have read; their value is don't-care.
- alloc_ready = (popcount(alloc_req) <= free_count). With alloc_req = 0, alloc_ready = 1 and nothing is consumed.
- Commit: on a clock edge where alloc_ready is high, head advances by popcount(alloc_req). When alloc_ready is low, nothing is consumed, no partial grant is made, and rename stalls.
- Release compaction: slot j writes entry tail + popcount(release_v[j-1:0]); tail advances by popcount(release_v).
- Release protocol: free_count + popcount(release_v) > DEPTH is a protocol violation. A simulation assertion fires, and hardware behaviour is undefined. Releasing preg 0..NUM_AREG-1 is legal; all registers are equivalent.
- Simultaneous allocate and release apply in the same cycle. Pointer arithmetic wraps naturally.

## Timing
- alloc_preg and alloc_ready are combinational from head, tail and alloc_req, with zero-cycle latency to rename.
- Pointer and entry updates happen at the posedge.
- No release-to-allocate bypass. A register released in cycle N is allocatable in cycle N+1 at the earliest.
- free_count reflects registered pointers. It updates one cycle after an allocate or release.
- rst overrides everything, including allocation and release in progress. Ring contents are reinitialised.

## Configuration
- FREE_LIST_FLUSH_EN defined:
  - Adds the `flush` port and a commit_head pointer (reset 0).
  - commit_head advances by popcount(release_v) each cycle. Each retiring destination corresponds one-to-one, in order, with one prior allocation.
  - On flush: head <= commit_head + popcount(release_v). Same-cycle releases still apply to tail. alloc_ready is forced to 0, so no allocation happens that cycle.
  - Effect: every speculatively allocated register returns to the free list in one cycle.
- Undefined: no flush port, no commit_head. Recovery is the responsibility of an external reset.

## Structure
- Shared package `core_pkg`:
  - PREG, AREG, DECODE_NUM, RETIRE_NUM
  - `preg_t` (logic [PREG-1:0])
  - NUM_PREG, NUM_AREG, FL_DEPTH constants
- One sub-module `prefix_popcount`: exclusive prefix counts and a total for an N-bit vector. It is instantiated twice, once for alloc_req and once for release_v.

## Test plan
- Reset, alloc_req=1111 -> alloc_ready=1, alloc_preg={32,33,34,35}; next cycle free_count=28.
- After reset, alloc_req=1010 -> slot1=32, slot3=33; next cycle free_count=30, next allocation starts at 34.
- Eight cycles of alloc_req=1111 -> free_count=0; ninth cycle alloc_ready=0; head and alloc_preg unchanged while stalled.
- At free_count=0: release_v=0011 with preg {5,9} and alloc_req=0001 -> alloc_ready=0 that cycle. Next cycle alloc_ready=1, alloc_preg[0]=5, then 9.
- 32 allocations and 32 releases of values 100-k mod 64 -> next allocation wraps to entry 0 and returns the first released value; free_count is never above 32.
- (FREE_LIST_FLUSH_EN) Two cycles of alloc 1111 (32..39, free_count=24), then release_v=0111 {1,2,3} with flush=1 -> next cycle free_count=32, alloc_preg[0]=35.
